// File: rtl/kt_cmd_pkg.sv
// Shared KnightsTour command-link definitions: opcodes, response codes and
// the state encodings used by the command UART wrapper and its transceiver.
package kt_cmd_pkg;

  localparam logic [3:0] OP_CAL  = 4'b0010;
  localparam logic [3:0] OP_MOVE = 4'b0100;
  localparam logic [3:0] OP_TOUR = 4'b0110;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  typedef enum logic {HIGH, LOW} asm_state_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/cmd_uart_wrapper_if.sv
// Command/response handshake between cmd_uart_wrapper (slave) and cmd_proc (master).
interface cmd_uart_wrapper_if;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;

  modport master (
    input  cmd, cmd_rdy, tx_done,
    output clr_cmd_rdy, trmt, resp
  );

  modport slave (
    output cmd, cmd_rdy, tx_done,
    input  clr_cmd_rdy, trmt, resp
  );

endinterface

// File: rtl/uart_xcvr.sv
// 8N1 UART transceiver: oversampling-free RX deserializer (mid-bit sampling)
// and a 10-bit shift-register TX serializer, BAUD_DIV clocks per bit.
module uart_xcvr
  import kt_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  // [1:0] synchronise RX, [2] is the history bit for edge detection
  logic [2:0]       rx_pipe_reg;
  logic             rx_s;
  logic             rx_fall;
  uart_state_t      rx_state_reg;
  logic [CNT_W-1:0] rx_cnt_reg;
  logic [2:0]       rx_bit_reg;
  logic [7:0]       rx_shift_reg;
  logic [7:0]       rx_data_reg;
  logic             rx_rdy_reg;

  tx_state_t        tx_state_reg;
  logic [9:0]       tx_shift_reg;
  logic [CNT_W-1:0] tx_cnt_reg;
  logic [3:0]       tx_bit_reg;
  logic             tx_done_reg;

  assign rx_s    = rx_pipe_reg[1];
  assign rx_fall = rx_pipe_reg[2] & ~rx_pipe_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_pipe_reg <= 3'b111;
    end else begin
      rx_pipe_reg <= {rx_pipe_reg[1:0], rx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_rdy_reg   <= 1'b0;
    end else begin
      rx_rdy_reg <= 1'b0;
      case (rx_state_reg)
        IDLE: begin
          if (rx_fall) begin
            rx_cnt_reg   <= HALF_BIT;
            rx_state_reg <= START;
          end
        end
        START: begin
          if (rx_cnt_reg == '0) begin
            // a start bit that is high again at mid-bit was only a glitch
            if (rx_s) begin
              rx_state_reg <= IDLE;
            end else begin
              rx_cnt_reg   <= FULL_BIT;
              rx_bit_reg   <= '0;
              rx_state_reg <= DATA;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt_reg == '0) begin
            rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
            rx_cnt_reg   <= FULL_BIT;
            rx_bit_reg   <= rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= STOP;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt_reg == '0) begin
            if (rx_s) begin
              rx_data_reg <= rx_shift_reg;
              rx_rdy_reg  <= 1'b1;
            end
            rx_state_reg <= IDLE;
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 1'b1;
          end
        end
        default: rx_state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= '1;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_done_reg  <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (trmt) begin
            tx_shift_reg <= {1'b1, tx_data, 1'b0};
            tx_cnt_reg   <= FULL_BIT;
            tx_bit_reg   <= '0;
            tx_done_reg  <= 1'b0;
            tx_state_reg <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tx_cnt_reg == '0) begin
            // shifting in ones leaves the line idle-high after the stop bit
            tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
            tx_cnt_reg   <= FULL_BIT;
            if (tx_bit_reg == 4'd9) begin
              tx_done_reg  <= 1'b1;
              tx_state_reg <= TX_IDLE;
            end else begin
              tx_bit_reg <= tx_bit_reg + 4'd1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 1'b1;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign tx      = tx_shift_reg[0];
  assign tx_done = tx_done_reg;
  assign rx_rdy  = rx_rdy_reg;
  assign rx_data = rx_data_reg;

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Remote-command UART front end: pairs received bytes (high first) into a
// 16-bit command with a ready/clear handshake and sends back response bytes.
// Define CMD_TIMEOUT_EN to abandon a half-received command after TMO_CLKS.
module cmd_uart_wrapper
  import kt_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TMO_CLKS = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RX,
  output logic                TX,
  cmd_uart_wrapper_if.slave   cmd_bus
);

  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       tx_done_w;

  asm_state_t  asm_state_reg;
  logic [7:0]  hi_byte_reg;
  logic [15:0] cmd_reg;
  logic        cmd_rdy_reg;
  logic        tmo_hit;

  uart_xcvr #(
    .BAUD_DIV (BAUD_DIV)
  ) u_xcvr (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .tx      (TX),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .trmt    (cmd_bus.trmt),
    .tx_data (cmd_bus.resp),
    .tx_done (tx_done_w)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CLKS + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;

  assign tmo_hit = (asm_state_reg == LOW) && (tmo_cnt_reg == TMO_W'(TMO_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (rx_rdy || (asm_state_reg != LOW) || tmo_hit) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CLKS > 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state_reg <= HIGH;
      hi_byte_reg   <= '0;
      cmd_reg       <= '0;
      cmd_rdy_reg   <= 1'b0;
    end else begin
      if (cmd_bus.clr_cmd_rdy) begin
        cmd_rdy_reg <= 1'b0;
      end
      // later assignments override the clear, so a same-cycle set wins
      if (rx_rdy) begin
        case (asm_state_reg)
          HIGH: begin
            hi_byte_reg   <= rx_data;
            cmd_rdy_reg   <= 1'b0;
            asm_state_reg <= LOW;
          end
          LOW: begin
            cmd_reg       <= {hi_byte_reg, rx_data};
            cmd_rdy_reg   <= 1'b1;
            asm_state_reg <= HIGH;
          end
          default: asm_state_reg <= HIGH;
        endcase
      end else if (tmo_hit) begin
        hi_byte_reg   <= '0;
        asm_state_reg <= HIGH;
      end
    end
  end

  assign cmd_bus.cmd     = cmd_reg;
  assign cmd_bus.cmd_rdy = cmd_rdy_reg;
  assign cmd_bus.tx_done = tx_done_w;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Scoreboard bench for cmd_uart_wrapper: a byte-level command model feeds
// expected commands/frames to monitors watching cmd_rdy and the TX line.
module tb_cmd_uart_wrapper;
  import kt_cmd_pkg::*;

  localparam int BD  = 16;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst_n;
  logic RX;
  logic TX;

  cmd_uart_wrapper_if bus ();

  cmd_uart_wrapper #(
    .BAUD_DIV (BD),
    .TMO_CLKS (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .cmd_bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];

  // byte-pairing reference model state
  bit         pend_valid = 1'b0;
  logic [7:0] pend_byte  = 8'h00;
  int         last_good_end = 0;

  logic        prev_rdy = 1'b0;
  logic [15:0] cmd_exp;
  logic        tx_prev = 1'b1;
  logic        tx_known;
  logic [7:0]  tx_exp;
  logic [9:0]  tx_frame;
  logic [9:0]  tx_got;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Pairs good bytes high-first; a long gap while half-paired drops the high byte
  task automatic model_byte(input logic [7:0] b);
    bit tmo_en;
`ifdef CMD_TIMEOUT_EN
    tmo_en = 1'b1;
`else
    tmo_en = 1'b0;
`endif
    if (tmo_en && pend_valid && ((cyc - last_good_end) + 10 * BD > TMO))
      pend_valid = 1'b0;
    if (!pend_valid) begin
      pend_valid = 1'b1;
      pend_byte  = b;
    end else begin
      exp_cmd_q.push_back({pend_byte, b});
      pend_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    if (good) model_byte(b);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = good;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    if (good) last_good_end = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_cmd_q.size() != 0 && n < 40 * BD) begin
      @(negedge clk);
      n++;
    end
    check_int({name, "_pending"}, exp_cmd_q.size(), 0);
    exp_cmd_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check1("clr_drops_rdy", bus.cmd_rdy, 1'b0);
  endtask

  task automatic send_resp(input logic [7:0] r);
    int t0;
    bus.resp = r;
    bus.trmt = 1'b1;
    exp_tx_q.push_back(r);
    @(negedge clk);
    bus.trmt = 1'b0;
    t0 = cyc;
    check1("tx_done_cleared", bus.tx_done, 1'b0);
    while (bus.tx_done !== 1'b1 && (cyc - t0) < 12 * BD) @(negedge clk);
    check_int("tx_done_latency", cyc - t0, 10 * BD);
  endtask

  task automatic rand_rx();
    logic [7:0] hi;
    logic [7:0] lo;
    for (int k = 0; k < 8; k++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge clk);
      send_byte(hi, 1'b1);
      repeat ($urandom_range(0, 40)) @(negedge clk);
      send_byte(lo, 1'b1);
      wait_drain("rand_cmd");
      check1("rand_rdy_held", bus.cmd_rdy, 1'b1);
      if ($urandom_range(0, 1) == 1) pulse_clr();
    end
  endtask

  task automatic rand_tx();
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      send_resp(8'($urandom));
    end
  endtask

  // command scoreboard: one expected command per cmd_rdy rising edge
  initial begin : mon_cmd
    forever begin
      @(negedge clk);
      if (bus.cmd_rdy === 1'b1 && prev_rdy !== 1'b1) begin
        if (exp_cmd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL cmd_unexpected: got %h, required no command", bus.cmd);
        end else begin
          cmd_exp = exp_cmd_q.pop_front();
          check16("cmd", bus.cmd, cmd_exp);
          $display("cmd transaction: got %h expected %h", bus.cmd, cmd_exp);
        end
      end
      prev_rdy = bus.cmd_rdy;
    end
  end

  // TX line decoder: samples each bit mid-period against the expected frame
  initial begin : mon_tx
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_prev === 1'b1 && TX === 1'b0) begin
        tx_known = (exp_tx_q.size() != 0);
        if (tx_known) begin
          tx_exp = exp_tx_q.pop_front();
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got a frame start, required idle line");
          tx_exp = 8'hFF;
        end
        tx_frame = {1'b1, tx_exp, 1'b0};
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          if (i > 0) repeat (BD) @(negedge clk);
          tx_got[i] = TX;
          if (tx_known) check1("tx_bit", TX, tx_frame[i]);
        end
        if (tx_known) $display("tx transaction: got %h expected %h", tx_got[8:1], tx_exp);
      end
      tx_prev = TX;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "bench time limit reached");
  end

  initial begin : main
    RX              = 1'b1;
    rst_n           = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.trmt        = 1'b0;
    bus.resp        = 8'h00;
    repeat (3) @(negedge clk);
    check1("rst_TX", TX, 1'b1);
    check16("rst_cmd", bus.cmd, 16'h0000);
    check1("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    check1("rst_tx_done", bus.tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // calibrate, held until cleared
    send_byte({OP_CAL, 4'h0}, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("cal");
    repeat (50) @(negedge clk);
    check1("rdy_held", bus.cmd_rdy, 1'b1);
    pulse_clr();

    // tour, then a new high byte makes the old command stale
    send_byte({OP_TOUR, 4'h0}, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_drain("tour");
    check1("tour_rdy", bus.cmd_rdy, 1'b1);
    send_byte({OP_MOVE, 4'h0}, 1'b1);
    check1("rdy_drop_on_high", bus.cmd_rdy, 1'b0);
    send_byte(8'h11, 1'b1);
    wait_drain("move");
    check1("move_rdy", bus.cmd_rdy, 1'b1);
    pulse_clr();

    // response frame with an ignored mid-frame request
    begin : tx_directed
      int t0;
      bus.resp = RESP_DONE;
      bus.trmt = 1'b1;
      exp_tx_q.push_back(RESP_DONE);
      @(negedge clk);
      bus.trmt = 1'b0;
      t0 = cyc;
      check1("tx_done_low_busy", bus.tx_done, 1'b0);
      repeat (3 * BD) @(negedge clk);
      bus.resp = RESP_BUSY;
      bus.trmt = 1'b1;
      @(negedge clk);
      bus.trmt = 1'b0;
      while (bus.tx_done !== 1'b1 && (cyc - t0) < 12 * BD) @(negedge clk);
      check_int("tx_done_latency_a5", cyc - t0, 10 * BD);
      repeat (3 * BD) @(negedge clk);
      check1("tx_done_held", bus.tx_done, 1'b1);
      check_int("tx_queue_empty", exp_tx_q.size(), 0);
    end

    // framing error and a short glitch produce nothing
    send_byte(8'h55, 1'b0);
    RX = 1'b0;
    repeat (BD / 4) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
    send_byte({OP_CAL, 4'h0}, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("after_errors");

    // reset after a lone high byte discards it
    send_byte({OP_TOUR, 4'h0}, 1'b1);
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    pend_valid = 1'b0;
    @(negedge clk);
    check1("midrst_TX", TX, 1'b1);
    check16("midrst_cmd", bus.cmd, 16'h0000);
    check1("midrst_cmd_rdy", bus.cmd_rdy, 1'b0);
    check1("midrst_tx_done", bus.tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte({OP_CAL, 4'h0}, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("after_reset");

    // receive and transmit concurrently with random traffic
    fork
      rand_rx();
      rand_tx();
    join
    repeat (2 * BD) @(negedge clk);

    // a clear held across completion still lets the new command be seen
    bus.clr_cmd_rdy = 1'b1;
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_drain("set_beats_clear");
    bus.clr_cmd_rdy = 1'b0;
    check1("clr_held_rdy", bus.cmd_rdy, 1'b0);

    // long gap between high and low byte
    send_byte({OP_TOUR, 4'h0}, 1'b1);
    repeat (1100) @(negedge clk);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("gap");

    repeat (4 * BD) @(negedge clk);
    check_int("tx_queue_final", exp_tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
